// File: rtl/ram_output_reader.sv
// ram_output_reader: streams len RAM words from base_addr over valid/ready; define OUT_CHECKSUM_EN to add the chk XOR port
module ram_output_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
`ifdef OUT_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] chk
`endif
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DN = 2'd2;
    logic [1:0] state;
    logic [ADDR_WIDTH:0] iss_left, beats_left;
    logic rd_v, q_v;
    logic [DATA_WIDTH-1:0] mem [3];
    logic [1:0] wp, rp, cnt;
    logic push, pop, issue;
    logic [2:0] occ;
    assign push = q_v;
    assign out_valid = cnt != 2'd0;
    assign pop = out_valid & out_ready;
    assign out_data = mem[rp];
    assign out_last = out_valid && beats_left == 1;
    assign busy = state == RUN;
    assign done = state == DN;
    // FIFO slots plus in-flight reads; a same-cycle pop frees one slot early
    assign occ = {1'b0, cnt} + {2'b0, rd_v} + {2'b0, q_v};
    assign issue = state == RUN && iss_left != 0 && occ < (pop ? 3'd4 : 3'd3);
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            iss_left <= '0;
            beats_left <= '0;
            rd_v <= 1'b0;
            q_v <= 1'b0;
            ram_addr <= '0;
            wp <= 2'd0;
            rp <= 2'd0;
            cnt <= 2'd0;
            for (int i = 0; i < 3; i++) mem[i] <= '0;
`ifdef OUT_CHECKSUM_EN
            chk <= '0;
`endif
        end else begin
            q_v <= rd_v;
            rd_v <= issue;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
            if (push) begin
                mem[wp] <= ram_q;
                wp <= (wp == 2'd2) ? 2'd0 : wp + 2'd1;
            end
            if (pop) begin
                rp <= (rp == 2'd2) ? 2'd0 : rp + 2'd1;
                beats_left <= beats_left - 1'b1;
`ifdef OUT_CHECKSUM_EN
                chk <= chk ^ out_data;
`endif
            end
            if (issue) begin
                ram_addr <= ram_addr + 1'b1;
                iss_left <= iss_left - 1'b1;
            end
            if (state == IDLE && start) begin
`ifdef OUT_CHECKSUM_EN
                chk <= '0;
`endif
                if (len == 0) begin
                    state <= DN;
                end else begin
                    state <= RUN;
                    ram_addr <= base_addr;
                    rd_v <= 1'b1;
                    iss_left <= len - 1'b1;
                    beats_left <= len;
                end
            end else if (state == RUN && pop && beats_left == 1) begin
                state <= DN;
            end else if (state == DN) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_ram_output_reader.sv
// tb_ram_output_reader: randomized and directed jobs checked against a queue-based reference model
module tb_ram_output_reader;
    localparam int DW = 8, AW = 4;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0] len = '0;
    logic busy, done, out_valid, out_last;
    logic [AW-1:0] ram_addr, ra;
    logic [DW-1:0] ram_q, out_data;
`ifdef OUT_CHECKSUM_EN
    logic [DW-1:0] chk;
`endif
    logic [DW-1:0] ram [16];
    int total = 0, bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) ra <= ram_addr;
    assign ram_q = ram[ra];

    ram_output_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .ram_addr(ram_addr), .ram_q(ram_q),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
`ifdef OUT_CHECKSUM_EN
        , .chk(chk)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic pick_ready(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return c[0];
        return ($urandom % 4) != 0;
    endfunction

    // mode: 0 always ready, 1 toggling, 2 random; abort_at: reset after that many beats; poke: start mid-job
    task automatic run_job(input logic [AW-1:0] b, input logic [AW:0] n, input int mode,
                           input int abort_at, input bit poke);
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] x, pd;
        logic pl, stalled;
        int k, c, first, last_c;
        bit fin;
        x = '0;
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back(ram[(int'(b) + i) % 16]);
            x ^= ram[(int'(b) + i) % 16];
        end
        @(negedge clk);
        start = 1'b1; base_addr = b; len = n;
        @(negedge clk);
        start = 1'b0;
        c = 1; k = 0; first = -1; last_c = -1; stalled = 1'b0; fin = 1'b0; pd = '0; pl = 1'b0;
        if (n != 0) check("addr0", ram_addr, b);
`ifdef OUT_CHECKSUM_EN
        check("chk_clear", chk, 0);
`endif
        while (!fin && c < 300) begin
            out_ready = pick_ready(mode, c);
            if (poke && c == 3) begin
                start = 1'b1; base_addr = 4'd9; len = 5'd5;
            end else start = 1'b0;
            if (n == 0) check("noval_len0", out_valid, 0);
            if (stalled) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, pd);
                check("hold_last", out_last, pl);
            end
            if (out_valid && first < 0) begin
                first = c;
                check("latency", c, 3);
            end
            if (mode == 0 && k > 0 && k < int'(n)) check("throughput", out_valid, 1);
            if (out_valid && out_ready) begin
                if (k < exp_q.size()) begin
                    check("data", out_data, exp_q[k]);
                    check("last", out_last, k == int'(n) - 1);
                end else check("extra_beat", out_valid, 0);
                k++;
                last_c = c;
            end
            stalled = out_valid && !out_ready;
            pd = out_data; pl = out_last;
            if (done) begin
                check("beats", k, n);
                check("busy_at_done", busy, 0);
                check("done_time", c, n == 0 ? 1 : last_c + 1);
`ifdef OUT_CHECKSUM_EN
                check("chk_done", chk, x);
`endif
                fin = 1'b1;
            end
            if (abort_at > 0 && k == abort_at) begin
                @(negedge clk);
                rst = 1'b1; out_ready = 1'b0;
                @(negedge clk);
                check("abort_valid", out_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_addr", ram_addr, 0);
                rst = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("abort_nodone", done, 0);
                    check("abort_noval", out_valid, 0);
                end
                return;
            end
            if (!fin) begin
                @(negedge clk);
                c++;
            end
        end
        start = 1'b0;
        if (!fin) check("timeout", c, 0);
        repeat (3) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_valid", out_valid, 0);
            check("idle_done", done, 0);
`ifdef OUT_CHECKSUM_EN
            check("chk_stable", chk, x);
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'h10 + 8'(i);
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        rst = 1'b0;
        run_job(4'd0, 5'd4, 0, 0, 1'b0);
        run_job(4'd14, 5'd4, 0, 0, 1'b0);
        run_job(4'd3, 5'd8, 1, 0, 1'b0);
        run_job(4'd7, 5'd0, 0, 0, 1'b0);
        run_job(4'd2, 5'd6, 0, 0, 1'b1);
        run_job(4'd1, 5'd6, 0, 2, 1'b0);
        run_job(4'd4, 5'd5, 0, 0, 1'b0);
        run_job(4'd5, 5'd16, 2, 0, 1'b0);
`ifdef OUT_CHECKSUM_EN
        ram[0] = 8'hA5; ram[1] = 8'h0F; ram[2] = 8'hF0;
        run_job(4'd0, 5'd3, 0, 0, 1'b0);
        check("t6_chk", chk, 8'h5A);
`endif
        repeat (20) begin
            for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
            run_job(4'($urandom % 16), 5'($urandom % 17), int'($urandom % 3), 0, 1'b0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
